// File: rtl/core_pkg.sv
// Shared core-wide widths, constants and payload types.
package core_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 32;

   // Canonical bubble encoding, used for cache pre-fill and bubble insertion.
   localparam logic [DATA_W-1:0] NOP_INSTR = {6'b111111, 26'd0};

   // One fetched instruction tagged with the word address it came from.
   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] instr;
   } fetch_entry_t;

   // Next sequential word address; wraps silently at the top of the space.
   function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
      return pc + ADDR_W'(1);
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_buffer
   import core_pkg::*;
#(
   parameter int unsigned  DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_pc,
   input  logic [DATA_W-1:0] push_instr,
   input  logic              pop,
   output logic [CNT_W-1:0]  count,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_pc,
   output logic [DATA_W-1:0] head_instr
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             do_push;
   logic             do_pop;

   // Flush wins over both ports; a push into a full FIFO is only legal alongside a pop.
   always_comb begin
      do_pop  = 1'b0;
      do_push = 1'b0;
      if (!flush) begin
         do_pop  = pop && (count != '0);
         do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
      end
   end

   // Entry storage; cleared on reset so the head reads zero until first written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clk_en && do_push) begin
         mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
      end
   end

   // Read/write pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clk_en) begin
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) begin
               wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
               2'b10:   count <= count + CNT_W'(1);
               2'b01:   count <= count - CNT_W'(1);
               default: count <= count;
            endcase
         end
      end
   end

   // Head view comes straight from stored state, never from the incoming word.
   assign head_valid = (count != '0);
   assign head_pc    = mem[rd_ptr].pc;
   assign head_instr = mem[rd_ptr].instr;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one in-flight cache read, credit-based issue, redirect.
module fetch_unit
   import core_pkg::*;
#(
   parameter int unsigned       DEPTH    = 2,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h000A
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clk_en,
   output logic [ADDR_W-1:0] read_addr,
   input  logic [DATA_W-1:0] read_data,
   input  logic              data_ready,
   output logic [DATA_W-1:0] instr_out,
   output logic [ADDR_W-1:0] instr_pc,
   output logic              instr_valid,
   input  logic              instr_ready,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc
);

   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] inflight_pc;
   logic              inflight_valid;
   logic [CNT_W-1:0]  count;

   logic              stall;
   logic              resp;
   logic              push;
   logic              pop;
   logic [OCC_W-1:0]  credit;
   logic              issue;

   // Response/handshake qualification and issue credit for this cycle.
   always_comb begin
      stall  = inflight_valid && !data_ready;
      resp   = inflight_valid && data_ready;
      push   = resp && !redirect;
      pop    = instr_valid && instr_ready && !redirect;
      credit = OCC_W'(count) + OCC_W'(push) - OCC_W'(pop) + OCC_W'(stall);
      issue  = !redirect && !stall && (credit < OCC_W'(DEPTH));
   end

   // Cache address: redirect target first, then the stalled request, else the next PC.
   always_comb begin
      read_addr = fetch_pc;
      if (redirect) begin
         read_addr = redirect_pc;
      end else if (stall) begin
         read_addr = inflight_pc;
      end
   end

   // Fetch PC and in-flight request tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc       <= RESET_PC;
         inflight_valid <= 1'b0;
         inflight_pc    <= '0;
      end else if (clk_en) begin
         if (redirect) begin
            inflight_valid <= 1'b1;
            inflight_pc    <= redirect_pc;
            fetch_pc       <= pc_inc(redirect_pc);
         end else if (issue) begin
            inflight_valid <= 1'b1;
            inflight_pc    <= fetch_pc;
            fetch_pc       <= pc_inc(fetch_pc);
         end else if (!stall) begin
            inflight_valid <= 1'b0;
         end
      end
   end

   // Tagged instruction buffer feeding decode.
   fetch_buffer #(
      .DEPTH (DEPTH)
   ) u_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .clk_en     (clk_en),
      .flush      (redirect),
      .push       (resp),
      .push_pc    (inflight_pc),
      .push_instr (read_data),
      .pop        (instr_valid && instr_ready),
      .count      (count),
      .head_valid (instr_valid),
      .head_pc    (instr_pc),
      .head_instr (instr_out)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus randomized bench for fetch_unit against a queue-based reference model.
module tb_fetch_unit;
   import core_pkg::*;

   localparam int unsigned DEPTH    = 2;
   localparam logic [15:0] RESET_PC = 16'h000A;

   logic        clk         = 1'b0;
   logic        rst_n       = 1'b0;
   logic        clk_en      = 1'b0;
   logic        data_ready  = 1'b0;
   logic        instr_ready = 1'b0;
   logic        redirect    = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic [15:0] read_addr;
   logic [31:0] read_data;
   logic [31:0] instr_out;
   logic [15:0] instr_pc;
   logic        instr_valid;
   logic [15:0] cache_addr  = 16'h0000;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state: next PC, one outstanding request, FIFO of PCs.
   logic [15:0] m_fetch_pc;
   logic [15:0] m_inf_pc;
   logic        m_inf_v;
   logic [15:0] m_q [$];

   fetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RESET_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .clk_en      (clk_en),
      .read_addr   (read_addr),
      .read_data   (read_data),
      .data_ready  (data_ready),
      .instr_out   (instr_out),
      .instr_pc    (instr_pc),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .redirect    (redirect),
      .redirect_pc (redirect_pc)
   );

   always #5 clk = ~clk;

   // One-cycle cache: captures the address at each enabled edge, returns mem[a] = a*3.
   always @(posedge clk) begin
      if (clk_en) cache_addr <= read_addr;
   end
   assign read_data = 32'(cache_addr) * 32'd3;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      return 32'(a) * 32'd3;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_fetch_pc = RESET_PC;
      m_inf_v    = 1'b0;
      m_inf_pc   = 16'h0000;
      m_q.delete();
   endtask

   // One clock: drive inputs, check the address mux, clock, step the model, check the head.
   task automatic cyc(input logic en, input logic rdy, input logic dr,
                      input logic rd, input logic [15:0] rpc);
      logic        stall;
      logic        push;
      logic        pop;
      int          occ;
      logic [15:0] exp_addr;
      clk_en      = en;
      instr_ready = rdy;
      data_ready  = dr;
      redirect    = rd;
      redirect_pc = rpc;
      #1;
      stall    = m_inf_v && !dr;
      exp_addr = rd ? rpc : (stall ? m_inf_pc : m_fetch_pc);
      chk("read_addr", 32'(read_addr), 32'(exp_addr));
      @(posedge clk);
      if (en) begin
         if (rd) begin
            m_q.delete();
            m_inf_v    = 1'b1;
            m_inf_pc   = rpc;
            m_fetch_pc = rpc + 16'd1;
         end else begin
            push = m_inf_v && dr;
            pop  = (m_q.size() > 0) && rdy;
            occ  = m_q.size() + int'(push) - int'(pop);
            if (pop)  void'(m_q.pop_front());
            if (push) m_q.push_back(m_inf_pc);
            if (!stall && (occ < int'(DEPTH))) begin
               m_inf_v    = 1'b1;
               m_inf_pc   = m_fetch_pc;
               m_fetch_pc = m_fetch_pc + 16'd1;
            end else if (!stall) begin
               m_inf_v = 1'b0;
            end
         end
      end
      #1;
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("instr_pc", 32'(instr_pc), 32'(m_q[0]));
         chk("instr_out", instr_out, mem_word(m_q[0]));
      end
      @(negedge clk);
   endtask

   initial begin
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_pc", 32'(instr_pc), 32'd0);
      chk("rst_out", instr_out, 32'd0);
      chk("rst_addr", 32'(read_addr), 32'(RESET_PC));
      rst_n = 1'b1;

      // Streaming from reset with an always-ready consumer.
      for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t1_pc", 32'(instr_pc), 32'h000E);
      chk("t1_out", instr_out, 32'd42);

      // Decode back-pressure, then release.
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

      // Cache stall, then recovery.
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

      // Redirect with a full buffer and a response arriving in the same cycle.
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 16'h0020);
      chk("t4_flush", 32'(instr_valid), 32'd0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t4_pc0", 32'(instr_pc), 32'h0020);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t4_pc1", 32'(instr_pc), 32'h0021);
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

      // Clock enable low: everything frozen, then resume.
      for (int i = 0; i < 4; i++)
         cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 16'h0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);

      // Asynchronous reset mid-stream, then redirect across the address wrap.
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(instr_valid), 32'd0);
      chk("arst_pc", 32'(instr_pc), 32'd0);
      chk("arst_out", instr_out, 32'd0);
      chk("arst_addr", 32'(read_addr), 32'(RESET_PC));
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFF);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t6_pc0", 32'(instr_pc), 32'h0000FFFF);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t6_pc1", 32'(instr_pc), 32'h00000000);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
      chk("t6_pc2", 32'(instr_pc), 32'h00000001);

      // Randomized traffic on all controls.
      for (int i = 0; i < 600; i++) begin
         cyc(1'($urandom_range(0, 9) != 0),
             1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 9) < 8),
             1'($urandom_range(0, 24) == 0),
             16'($urandom));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
